// File: rtl/dragon_pkg.sv
// Shared constants and encodings for the dragon body trail: tile geometry,
// facing directions and the collision-scan FSM states.
package dragon_pkg;

    localparam int LOC_W   = 8;
    localparam int MAX_SEG = 16;
    localparam int IDX_W   = 4;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dragon_trail_scanner.sv
// Collision scanner: walks the trail one entry per cycle after each head move
// and publishes self/player hit flags in a single DONE cycle.
module dragon_trail_scanner
    import dragon_pkg::*;
#(
    parameter int SEG_LOC_W = LOC_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_head_valid,
    input  logic [IDX_W-1:0]     i_len,
    input  logic [SEG_LOC_W-1:0] i_head_loc,
    input  logic [SEG_LOC_W-1:0] i_ply_loc,
    input  logic [SEG_LOC_W-1:0] i_seg_loc,
    input  logic                 i_seg_vld,
    output state_t               o_state,
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_self_hit,
    output logic                 o_player_hit,
    output logic                 o_overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_SEG - 1);

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_idx;
    logic             r_acc_self;
    logic             r_acc_ply;
    logic             r_self_hit;
    logic             r_player_hit;
    logic             r_overrun;
    logic             w_active;
    logic             w_self_now;
    logic             w_ply_now;

    assign w_active   = (r_idx < i_len) && i_seg_vld;
    assign w_self_now = w_active && (i_seg_loc == i_head_loc);
    assign w_ply_now  = w_active && (i_seg_loc == i_ply_loc);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_head_valid) w_next = SCAN;
            SCAN:    if (r_idx == LAST_IDX) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_acc_self   <= 1'b0;
            r_acc_ply    <= 1'b0;
            r_self_hit   <= 1'b0;
            r_player_hit <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state <= w_next;
            // Any move request outside IDLE is dropped but remembered.
            if (i_head_valid && (r_state != IDLE)) r_overrun <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (i_head_valid) begin
                        r_idx      <= '0;
                        r_acc_self <= 1'b0;
                        r_acc_ply  <= 1'b0;
                    end
                end
                SCAN: begin
                    if (r_idx == LAST_IDX) begin
                        r_self_hit   <= r_acc_self | w_self_now;
                        r_player_hit <= r_acc_ply | w_ply_now;
                        r_idx        <= '0;
                    end else begin
                        r_acc_self <= r_acc_self | w_self_now;
                        r_acc_ply  <= r_acc_ply | w_ply_now;
                        r_idx      <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_state      = r_state;
    assign o_idx        = r_idx;
    assign o_self_hit   = r_self_hit;
    assign o_player_hit = r_player_hit;
    assign o_overrun    = r_overrun;

endmodule

// File: rtl/dragon_body_trail.sv
// Dragon body trail: a shift register of past head positions with a
// renderer read port and a background collision scan after every move.
module dragon_body_trail #(
    parameter int MAX_SEG = dragon_pkg::MAX_SEG,
    parameter int LOC_W   = dragon_pkg::LOC_W
) (
    input  logic             frame_clk,
    input  logic             rst_n,
    input  logic             head_valid,
    input  logic [LOC_W-1:0] head_location,
    input  logic [1:0]       head_direction,
    input  logic [3:0]       body_length,
    input  logic [LOC_W-1:0] player_location,
    input  logic             rd_req,
    input  logic [3:0]       rd_index,
    output logic             rd_valid,
    output logic [LOC_W-1:0] rd_location,
    output logic [1:0]       rd_direction,
    output logic             rd_active,
    output logic             busy,
    output logic             scan_done,
    output logic             self_hit,
    output logic             player_hit,
    output logic             overrun
);
    import dragon_pkg::*;

    logic [LOC_W-1:0]   r_seg_loc [MAX_SEG];
    dir_t               r_seg_dir [MAX_SEG];
    logic [MAX_SEG-1:0] r_seg_vld;
    logic [LOC_W-1:0]   r_head_q;
    dir_t               r_hdir_q;
    logic               r_head_vld;
    logic [3:0]         r_len_q;
    logic [LOC_W-1:0]   r_ply_q;

    logic               r_rd_valid;
    logic [LOC_W-1:0]   r_rd_location;
    logic [1:0]         r_rd_direction;
    logic               r_rd_active;

    state_t             w_state;
    logic [IDX_W-1:0]   w_idx;
    logic               w_shift;

    assign w_shift = head_valid && (w_state == IDLE);

    // seg[0] receives the previous head, so the new head is never in the trail.
    always_ff @(posedge frame_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_SEG; i++) begin
                r_seg_loc[i] <= '0;
                r_seg_dir[i] <= UP;
            end
            r_seg_vld  <= '0;
            r_head_q   <= '0;
            r_hdir_q   <= UP;
            r_head_vld <= 1'b0;
            r_len_q    <= '0;
            r_ply_q    <= '0;
        end else if (w_shift) begin
            for (int i = MAX_SEG - 1; i > 0; i--) begin
                r_seg_loc[i] <= r_seg_loc[i-1];
                r_seg_dir[i] <= r_seg_dir[i-1];
            end
            r_seg_loc[0] <= r_head_q;
            r_seg_dir[0] <= r_hdir_q;
            r_seg_vld    <= {r_seg_vld[MAX_SEG-2:0], r_head_vld};
            r_head_q     <= head_location;
            r_hdir_q     <= dir_t'(head_direction);
            r_head_vld   <= 1'b1;
            r_len_q      <= body_length;
            r_ply_q      <= player_location;
        end
    end

    always_ff @(posedge frame_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid     <= 1'b0;
            r_rd_location  <= '0;
            r_rd_direction <= '0;
            r_rd_active    <= 1'b0;
        end else begin
            r_rd_valid <= rd_req;
            if (rd_req) begin
                r_rd_location  <= r_seg_loc[rd_index];
                r_rd_direction <= r_seg_dir[rd_index];
                r_rd_active    <= (rd_index < r_len_q) && r_seg_vld[rd_index];
            end
        end
    end

    dragon_trail_scanner #(
        .SEG_LOC_W (LOC_W)
    ) u_scanner (
        .i_clk        (frame_clk),
        .i_rst_n      (rst_n),
        .i_head_valid (head_valid),
        .i_len        (r_len_q),
        .i_head_loc   (r_head_q),
        .i_ply_loc    (r_ply_q),
        .i_seg_loc    (r_seg_loc[w_idx]),
        .i_seg_vld    (r_seg_vld[w_idx]),
        .o_state      (w_state),
        .o_idx        (w_idx),
        .o_self_hit   (self_hit),
        .o_player_hit (player_hit),
        .o_overrun    (overrun)
    );

    assign busy         = (w_state != IDLE);
    assign scan_done    = (w_state == DONE);
    assign rd_valid     = r_rd_valid;
    assign rd_location  = r_rd_location;
    assign rd_direction = r_rd_direction;
    assign rd_active    = r_rd_active;

endmodule

// File: tb/tb_dragon_body_trail.sv
// Bench for dragon_body_trail: directed scenarios plus randomized moves,
// checked against a queue-based model of the trail.
module tb_dragon_body_trail;

    logic       frame_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       head_valid = 1'b0;
    logic [7:0] head_location = '0;
    logic [1:0] head_direction = '0;
    logic [3:0] body_length = '0;
    logic [7:0] player_location = '0;
    logic       rd_req = 1'b0;
    logic [3:0] rd_index = '0;
    logic       rd_valid;
    logic [7:0] rd_location;
    logic [1:0] rd_direction;
    logic       rd_active;
    logic       busy;
    logic       scan_done;
    logic       self_hit;
    logic       player_hit;
    logic       overrun;

    always #5 frame_clk = ~frame_clk;

    dragon_body_trail dut (
        .frame_clk       (frame_clk),
        .rst_n           (rst_n),
        .head_valid      (head_valid),
        .head_location   (head_location),
        .head_direction  (head_direction),
        .body_length     (body_length),
        .player_location (player_location),
        .rd_req          (rd_req),
        .rd_index        (rd_index),
        .rd_valid        (rd_valid),
        .rd_location     (rd_location),
        .rd_direction    (rd_direction),
        .rd_active       (rd_active),
        .busy            (busy),
        .scan_done       (scan_done),
        .self_hit        (self_hit),
        .player_hit      (player_hit),
        .overrun         (overrun)
    );

    typedef struct packed {
        logic       vld;
        logic [1:0] dir;
        logic [7:0] loc;
    } ent_t;

    ent_t        m_trail[$];
    logic [7:0]  m_head;
    logic [1:0]  m_hdir;
    logic        m_hvld;
    logic [3:0]  m_len;
    logic [7:0]  m_ply;
    logic        m_self, m_phit, m_ovr;
    logic        m_pend_self, m_pend_phit;
    logic [10:0] exp_q[$];

    int total = 0;
    int bad = 0;
    int since_push = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge frame_clk);
        since_push++;
    endtask

    task automatic model_reset();
        m_trail.delete();
        for (int i = 0; i < 16; i++) m_trail.push_back('0);
        m_head = '0; m_hdir = '0; m_hvld = 1'b0; m_len = '0; m_ply = '0;
        m_self = 1'b0; m_phit = 1'b0; m_ovr = 1'b0;
        m_pend_self = 1'b0; m_pend_phit = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_push(input logic [7:0] loc, input logic [1:0] dir,
                              input logic [3:0] len, input logic [7:0] ply);
        m_trail.push_front({m_hvld, m_hdir, m_head});
        void'(m_trail.pop_back());
        m_head = loc; m_hdir = dir; m_hvld = 1'b1; m_len = len; m_ply = ply;
        m_pend_self = 1'b0;
        m_pend_phit = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i < int'(m_len) && m_trail[i].vld) begin
                if (m_trail[i].loc == m_head) m_pend_self = 1'b1;
                if (m_trail[i].loc == m_ply) m_pend_phit = 1'b1;
            end
        end
    endtask

    task automatic expect_read(input logic [3:0] idx);
        ent_t e;
        e = m_trail[idx];
        exp_q.push_back({(int'(idx) < int'(m_len)) && e.vld, e.dir, e.loc});
    endtask

    task automatic check_read();
        logic [10:0] e;
        e = exp_q.pop_front();
        check_val("rd_valid", rd_valid, 1);
        check_val("rd_location", rd_location, e[7:0]);
        check_val("rd_direction", rd_direction, e[9:8]);
        check_val("rd_active", rd_active, e[10]);
    endtask

    task automatic do_read(input logic [3:0] idx);
        logic [7:0] held;
        rd_req = 1'b1;
        rd_index = idx;
        expect_read(idx);
        held = m_trail[idx].loc;
        tick();
        rd_req = 1'b0;
        rd_index = 4'($urandom_range(0, 15));
        check_read();
        tick();
        check_val("rd_idle_valid", rd_valid, 0);
        check_val("rd_idle_hold", rd_location, held);
    endtask

    task automatic push(input logic [7:0] loc, input logic [1:0] dir, input logic [3:0] len,
                        input logic [7:0] ply, input bit with_rd, input logic [3:0] ridx);
        head_location = loc; head_direction = dir; body_length = len; player_location = ply;
        head_valid = 1'b1;
        if (with_rd) begin
            rd_req = 1'b1;
            rd_index = ridx;
            expect_read(ridx);
        end
        @(negedge frame_clk);
        head_valid = 1'b0;
        rd_req = 1'b0;
        model_push(loc, dir, len, ply);
        since_push = 1;
        if (with_rd) check_read();
    endtask

    task automatic wait_done();
        while (scan_done !== 1'b1 && since_push < 40) tick();
        m_self = m_pend_self;
        m_phit = m_pend_phit;
        check_val("scan_latency", since_push, 17);
        check_val("self_hit", self_hit, m_self);
        check_val("player_hit", player_hit, m_phit);
        check_val("overrun", overrun, m_ovr);
        check_val("busy_in_done", busy, 1);
        tick();
        check_val("scan_done_pulse", scan_done, 0);
        check_val("busy_idle", busy, 0);
        check_val("self_hit_hold", self_hit, m_self);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_scan_done", scan_done, 0);
        check_val("rst_self_hit", self_hit, 0);
        check_val("rst_player_hit", player_hit, 0);
        check_val("rst_overrun", overrun, 0);
        check_val("rst_rd_valid", rd_valid, 0);
        check_val("rst_rd_location", rd_location, 0);
        check_val("rst_rd_direction", rd_direction, 0);
        check_val("rst_rd_active", rd_active, 0);
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int seen;
        logic [7:0] rl, rp;

        @(negedge frame_clk);
        do_reset();

        // Three moves, length 2: newest two trail entries active.
        push(8'h11, 2'd1, 4'd2, 8'h00, 1'b0, 4'd0); wait_done();
        push(8'h12, 2'd1, 4'd2, 8'h00, 1'b0, 4'd0); wait_done();
        push(8'h13, 2'd1, 4'd2, 8'h00, 1'b0, 4'd0); wait_done();
        do_read(4'd0);
        check_val("s1_idx0_loc", rd_location, 8'h12);
        do_read(4'd1);
        check_val("s1_idx1_loc", rd_location, 8'h11);
        do_read(4'd2);

        // Closed loop back onto the starting tile.
        do_reset();
        push(8'h11, 2'd1, 4'd4, 8'hff, 1'b0, 4'd0); wait_done();
        push(8'h12, 2'd1, 4'd4, 8'hff, 1'b0, 4'd0); wait_done();
        push(8'h22, 2'd2, 4'd4, 8'hff, 1'b0, 4'd0); wait_done();
        push(8'h21, 2'd3, 4'd4, 8'hff, 1'b0, 4'd0); wait_done();
        push(8'h11, 2'd0, 4'd4, 8'hff, 1'b0, 4'd0); wait_done();
        check_val("s2_self_hit_const", self_hit, 1);

        // Player on trail index 1: length 3 hits, length 1 does not.
        for (int k = 0; k < 2; k++) begin
            logic [3:0] len;
            len = (k == 0) ? 4'd3 : 4'd1;
            do_reset();
            push(8'h11, 2'd1, len, 8'h12, 1'b0, 4'd0); wait_done();
            push(8'h12, 2'd1, len, 8'h12, 1'b0, 4'd0); wait_done();
            push(8'h13, 2'd1, len, 8'h12, 1'b0, 4'd0); wait_done();
            push(8'h14, 2'd1, len, 8'h12, 1'b0, 4'd0); wait_done();
            check_val("s3_player_hit_const", player_hit, (k == 0) ? 1 : 0);
        end

        // Move request mid-scan, with length/player also changed mid-scan.
        do_reset();
        push(8'h11, 2'd1, 4'd4, 8'h13, 1'b0, 4'd0); wait_done();
        push(8'h12, 2'd1, 4'd4, 8'h13, 1'b0, 4'd0); wait_done();
        push(8'h13, 2'd1, 4'd4, 8'h13, 1'b0, 4'd0); wait_done();
        push(8'h12, 2'd3, 4'd4, 8'h13, 1'b0, 4'd0);
        while (since_push < 5) tick();
        head_valid = 1'b1; head_location = 8'h77; body_length = 4'd0; player_location = 8'h55;
        tick();
        head_valid = 1'b0;
        m_ovr = 1'b1;
        wait_done();
        check_val("s4_self_const", self_hit, 1);
        check_val("s4_player_const", player_hit, 1);
        do_read(4'd0);
        check_val("s4_no_shift", rd_location, 8'h13);
        push(8'h22, 2'd2, 4'd4, 8'h13, 1'b1, 4'd0);
        wait_done();
        do_read(4'd0);
        check_val("s4_head_kept", rd_location, 8'h12);

        // Reset in the middle of a scan.
        push(8'h21, 2'd0, 4'd3, 8'h12, 1'b0, 4'd0);
        while (since_push < 8) tick();
        do_reset();
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (scan_done === 1'b1) seen++;
        end
        check_val("s5_no_done", seen, 0);
        for (int i = 0; i < 16; i++) do_read(4'(i));
        push(8'h55, 2'd1, 4'd5, 8'h00, 1'b0, 4'd0); wait_done();
        do_read(4'd0);

        // Randomized moves with reads, some on the shift edge or mid-scan.
        for (int n = 0; n < 40; n++) begin
            rl = {4'($urandom_range(1, 2)), 4'($urandom_range(1, 2))};
            rp = {4'($urandom_range(1, 2)), 4'($urandom_range(1, 2))};
            push(rl, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), rp,
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1) do_read(4'($urandom_range(0, 15)));
            wait_done();
            do_read(4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dragon_body_trail.md
DRAGON_BODY_TRAIL -- requirements
Module: dragon_body_trail

Interface
REQ-001 SHALL have parameter MAX_SEG, default 16: trail storage depth, fixed by the 4-bit length field.
REQ-002 SHALL have parameter LOC_W, default 8: tile location width, {y[7:4], x[3:0]}.
REQ-003 SHALL have port frame_clk, input, 1: the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port head_valid, input, 1: one-cycle pulse meaning the head has moved one tile.
REQ-006 SHALL have port head_location, input, 8: new head tile.
REQ-007 SHALL have port head_direction, input, 2: new head facing direction.
REQ-008 SHALL have port body_length, input, 4: number of active body segments, 0..15.
REQ-009 SHALL have port player_location, input, 8: player tile.
REQ-010 SHALL have port rd_req, input, 1: renderer read request.
REQ-011 SHALL have port rd_index, input, 4: segment to read; 0 is the segment nearest the head.
REQ-012 SHALL have port rd_valid, output, 1: read data valid.
REQ-013 SHALL have port rd_location, output, 8: location of the read segment.
REQ-014 SHALL have port rd_direction, output, 2: direction of the read segment.
REQ-015 SHALL have port rd_active, output, 1: the read segment is within length and holds valid data.
REQ-016 SHALL have port busy, output, 1: high in states SCAN and DONE.
REQ-017 SHALL have port scan_done, output, 1: one-cycle pulse; hit flags are updated.
REQ-018 SHALL have port self_hit, output, 1: new head overlaps an active segment.
REQ-019 SHALL have port player_hit, output, 1: player overlaps an active segment.
REQ-020 SHALL have port overrun, output, 1: sticky flag; head_valid arrived while busy.

Function
REQ-021 Storage SHALL consist of seg_loc[0..15], seg_dir[0..15] and seg_vld[0..15], plus a head register (head_q, hdir_q, head_vld).
REQ-022 When head_valid is high in IDLE, on the next edge the block SHALL:
- shift seg[i] <= seg[i-1] for i = 15..1;
- load seg[0] <= {head_q, hdir_q, head_vld};
- load head_q <= head_location, hdir_q <= head_direction, head_vld <= 1;
- latch body_length into len_q and player_location into ply_q;
- set scan index to 0 and enter SCAN.
REQ-023 In SCAN, the block SHALL compare one entry per cycle, index 0..15 (16 cycles).
REQ-024 An entry SHALL be active only if its index < len_q and its seg_vld = 1.
REQ-025 self_hit accumulates (active AND seg_loc == head_q); player_hit accumulates (active AND seg_loc == ply_q).
REQ-026 After index 15, the FSM SHALL enter DONE for one cycle.
- In DONE, scan_done = 1 and the registered self_hit and player_hit take the accumulated values.
- The FSM then returns to IDLE.
- Latency: head_valid in cycle T gives scan_done in cycle T+17.
REQ-027 self_hit and player_hit SHALL hold their values until the next DONE.
REQ-028 head_valid while busy SHALL be ignored: no shift, and overrun is set.
REQ-029 Changes to body_length or player_location during SCAN SHALL NOT affect the scan in progress.
REQ-030 Read port:
- rd_req sampled high at edge E gives rd_valid = 1 in the following cycle.
- rd_location and rd_direction come from entry rd_index; rd_active = (rd_index < len_q) AND seg_vld.
- A read sampled on the same edge as a shift SHALL return the pre-shift contents.
REQ-031 rd_valid SHALL be 0 in any cycle following an edge with rd_req = 0; the read data outputs hold their last values.
REQ-032 body_length = 0 SHALL produce no hits and rd_active = 0 for every index.
REQ-033 Reads SHALL be serviced in every state, including SCAN.

Reset
REQ-034 While rst_n = 0, the block SHALL asynchronously return to the following values:
- FSM = IDLE, scan index = 0;
- all seg_vld = 0, all seg_loc = 0, all seg_dir = 0;
- head_q = 0, hdir_q = 0, head_vld = 0;
- len_q = 0, ply_q = 0;
- rd_valid = 0, rd_location = 0, rd_direction = 0, rd_active = 0;
- busy = 0, scan_done = 0, self_hit = 0, player_hit = 0, overrun = 0.
REQ-035 Reset asserted mid-scan SHALL abort the scan with no scan_done pulse; the first head_valid after reset pushes an invalid entry (head_vld = 0) into seg[0].

Structure
REQ-036 Shared package dragon_pkg SHALL hold LOC_W, MAX_SEG, the direction encodings (UP = 0, RIGHT = 1, DOWN = 2, LEFT = 3) and the FSM state encodings (IDLE, SCAN, DONE).
REQ-037 The compare FSM and accumulators SHALL be a single sub-module, dragon_trail_scanner; the storage and read port stay in the top module.

Verification
REQ-038 The bench SHALL cover at least these five directed scenarios:
- Reset, then head_valid with 0x11, 0x12, 0x13, body_length = 2 -> read idx 0 = 0x12 active; idx 1 = 0x11 active; idx 2 rd_active = 0.
- Path 0x11 -> 0x12 -> 0x22 -> 0x21 -> 0x11 with body_length = 4 -> scan_done 17 cycles after the last head_valid, with self_hit = 1.
- player_location = 0x12 on a trail containing 0x12 at index 1 with length 3 -> player_hit = 1; same stimulus with length 1 -> player_hit = 0.
- head_valid pulsed 5 cycles into SCAN -> no shift occurs, overrun = 1, and the scan result is unchanged.
- rst_n low during SCAN cycle 8 -> no scan_done pulse, all outputs 0, and every rd_active = 0 afterwards.
